// File: rtl/noc_pkt_ctrl.sv
// NoC packet flow controller: round-robin source grant, beat generation, ack, dst hand-off.
// Optional ack watchdog enabled by defining ACK_TIMEOUT_EN.
module noc_pkt_ctrl #(
  parameter int NUM_CH      = 4,
  parameter int CNT_W       = 4,
  parameter int PKT_LEN     = 8,
  parameter int ACK_TIMEOUT = 16,
  localparam int CH_W       = $clog2(NUM_CH)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NUM_CH-1:0] src_valid,
  output logic [NUM_CH-1:0] src_ready,
  input  logic              packet_valid,
  output logic              en_gen,
  output logic [CH_W-1:0]   gen_ch,
  output logic [CNT_W-1:0]  beat_cnt,
  input  logic              ack,
  output logic              dst_valid,
  input  logic              dst_ready,
  output logic [CH_W-1:0]   dst_ch,
  output logic              busy,
  output logic              timeout_err
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_GEN  = 2'd1;
  localparam logic [1:0] S_PROC = 2'd2;
  localparam logic [1:0] S_WAIT = 2'd3;

  if (NUM_CH < 2) begin : g_bad_num_ch
  end
  if (PKT_LEN < 1 || PKT_LEN > (1 << CNT_W)) begin : g_bad_pkt_len
  end
  if (ACK_TIMEOUT < 1) begin : g_bad_ack_timeout
  end

  logic [1:0]       state;
  logic [1:0]       state_d;
  logic [CH_W-1:0]  rr_ptr;
  logic [CH_W-1:0]  rr_next;
  logic [CH_W-1:0]  gen_ch_q;
  logic [CNT_W-1:0] beat_q;
  logic             grant_vld;
  logic [CH_W-1:0]  grant_idx;
  logic [CH_W-1:0]  idx;
  logic             st_idle;
  logic             st_gen;
  logic             st_proc;
  logic             st_wait;
  logic             last_beat;
  logic             to_hit;

  assign st_idle = (state == S_IDLE);
  assign st_gen  = (state == S_GEN);
  assign st_proc = (state == S_PROC);
  assign st_wait = (state == S_WAIT);

  // Scan downwards so the nearest requester at/after rr_ptr wins.
  always_comb begin
    grant_vld = 1'b0;
    grant_idx = '0;
    idx       = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      idx = CH_W'((int'(rr_ptr) + i) % NUM_CH);
      if (src_valid[idx]) begin
        grant_vld = 1'b1;
        grant_idx = idx;
      end
    end
  end

  assign rr_next = (grant_idx == CH_W'(NUM_CH - 1)) ?
                   '0 : grant_idx + CH_W'(1);

  assign last_beat = (beat_q == CNT_W'(PKT_LEN - 1));

  always_comb begin
    state_d = state;
    unique case (1'b1)
      st_idle: if (grant_vld) state_d = S_GEN;
      st_gen:  if (packet_valid && last_beat) state_d = S_PROC;
      st_proc: begin
        if (ack)
          state_d = dst_ready ? S_IDLE : S_WAIT;
        else if (to_hit)
          state_d = S_IDLE;
      end
      st_wait: if (dst_ready) state_d = S_IDLE;
      default: state_d = state;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= S_IDLE;
      rr_ptr   <= '0;
      gen_ch_q <= '0;
      beat_q   <= '0;
    end else begin
      state <= state_d;
      if (st_idle && grant_vld) begin
        gen_ch_q <= grant_idx;
        rr_ptr   <= rr_next;
      end
      if (en_gen)
        beat_q <= last_beat ? '0 : beat_q + CNT_W'(1);
    end
  end

`ifdef ACK_TIMEOUT_EN
  localparam int TO_W = $clog2(ACK_TIMEOUT + 1);

  logic [TO_W-1:0] to_cnt;
  logic            to_err_q;

  // Terminal cycle is the ACK_TIMEOUT-th PROCESS cycle; ack there still wins.
  assign to_hit = st_proc && !ack &&
                  (to_cnt == TO_W'(ACK_TIMEOUT - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      to_cnt   <= '0;
      to_err_q <= 1'b0;
    end else begin
      to_cnt   <= st_proc ? to_cnt + TO_W'(1) : '0;
      to_err_q <= to_hit;
    end
  end

  assign timeout_err = to_err_q;
`else
  assign to_hit      = 1'b0;
  assign timeout_err = 1'b0;
`endif

  assign src_ready = (st_idle && grant_vld) ?
                     (NUM_CH'(1) << grant_idx) : '0;
  assign en_gen    = st_gen && packet_valid;
  assign dst_valid = (st_proc && ack) || st_wait;
  assign busy      = !st_idle;
  assign gen_ch    = gen_ch_q;
  assign dst_ch    = gen_ch_q;
  assign beat_cnt  = beat_q;

endmodule

// File: tb/tb_noc_pkt_ctrl.sv
// Bench for noc_pkt_ctrl: directed scenarios plus random traffic
// against a transaction-level reference model.
module tb_noc_pkt_ctrl;

  localparam int NUM_CH      = 4;
  localparam int CNT_W       = 4;
  localparam int PKT_LEN     = 8;
  localparam int ACK_TIMEOUT = 16;
  localparam int CH_W        = 2;

  localparam int P_IDLE = 0;
  localparam int P_GEN  = 1;
  localparam int P_PROC = 2;
  localparam int P_WAIT = 3;

  logic              clk;
  logic              reset;
  logic [NUM_CH-1:0] src_valid;
  logic [NUM_CH-1:0] src_ready;
  logic              packet_valid;
  logic              en_gen;
  logic [CH_W-1:0]   gen_ch;
  logic [CNT_W-1:0]  beat_cnt;
  logic              ack;
  logic              dst_valid;
  logic              dst_ready;
  logic [CH_W-1:0]   dst_ch;
  logic              busy;
  logic              timeout_err;

  noc_pkt_ctrl #(
    .NUM_CH(NUM_CH), .CNT_W(CNT_W),
    .PKT_LEN(PKT_LEN), .ACK_TIMEOUT(ACK_TIMEOUT)
  ) dut (
    .clk(clk), .reset(reset),
    .src_valid(src_valid), .src_ready(src_ready),
    .packet_valid(packet_valid), .en_gen(en_gen),
    .gen_ch(gen_ch), .beat_cnt(beat_cnt),
    .ack(ack), .dst_valid(dst_valid),
    .dst_ready(dst_ready), .dst_ch(dst_ch),
    .busy(busy), .timeout_err(timeout_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;

  int m_ph, m_rr, m_ch, m_beats, m_wait;
  bit m_tmo;
  int q_ch[$];

  int cyc_n   = 0;
  int en_cnt  = 0;
  int dv_cnt  = 0;
  int xfr_cnt = 0;
  int tmo_cyc = -1000;

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int pick(logic [3:0] sv, int rr);
    for (int k = 0; k < NUM_CH; k++) begin
      int j;
      j = (rr + k) % NUM_CH;
      if (((sv >> j) & 4'd1) != 4'd0) return j;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_ph    = P_IDLE;
    m_rr    = 0;
    m_ch    = 0;
    m_beats = 0;
    m_wait  = 0;
    m_tmo   = 1'b0;
    q_ch.delete();
  endtask

  // One clock: drive at edge+1, check at edge+2, advance the model.
  task automatic cyc(logic [3:0] sv, logic pv, logic a, logic dr);
    int g;
    cyc_n++;
    src_valid    = sv;
    packet_valid = pv;
    ack          = a;
    dst_ready    = dr;
    #1;
    g = (m_ph == P_IDLE) ? pick(sv, m_rr) : -1;
    chk("src_ready", 32'(src_ready), (g >= 0) ? (1 << g) : 0);
    chk("en_gen", 32'(en_gen), 32'(m_ph == P_GEN && pv));
    chk("dst_valid", 32'(dst_valid),
        32'((m_ph == P_PROC && a) || m_ph == P_WAIT));
    chk("busy", 32'(busy), 32'(m_ph != P_IDLE));
    chk("beat_cnt", 32'(beat_cnt), m_beats);
    chk("gen_ch", 32'(gen_ch), m_ch);
    chk("dst_ch", 32'(dst_ch), m_ch);
    chk("timeout_err", 32'(timeout_err), 32'(m_tmo));
    if (en_gen) en_cnt++;
    if (dst_valid) dv_cnt++;
    if (timeout_err) tmo_cyc = cyc_n;
    if (dst_valid && dst_ready) begin
      xfr_cnt++;
      chk("xfer_outstanding", q_ch.size(), 1);
      if (q_ch.size() > 0) chk("xfer_ch", 32'(dst_ch), q_ch.pop_front());
    end
    m_tmo = 1'b0;
    case (m_ph)
      P_IDLE: if (g >= 0) begin
        m_ch  = g;
        m_rr  = (g + 1) % NUM_CH;
        m_ph  = P_GEN;
        q_ch.push_back(g);
      end
      P_GEN: if (pv) begin
        m_beats++;
        if (m_beats == PKT_LEN) begin
          m_beats = 0;
          m_ph    = P_PROC;
          m_wait  = 0;
        end
      end
      P_PROC: begin
        if (a) m_ph = dr ? P_IDLE : P_WAIT;
        else begin
          m_wait++;
`ifdef ACK_TIMEOUT_EN
          if (m_wait == ACK_TIMEOUT) begin
            m_ph  = P_IDLE;
            m_tmo = 1'b1;
            if (q_ch.size() > 0) void'(q_ch.pop_front());
          end
`endif
        end
      end
      default: if (dr) m_ph = P_IDLE;
    endcase
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    src_valid    = '0;
    packet_valid = 1'b0;
    ack          = 1'b0;
    dst_ready    = 1'b0;
    reset        = 1'b1;
    #1;
    chk("rst_busy", 32'(busy), 0);
    chk("rst_src_ready", 32'(src_ready), 0);
    chk("rst_en_gen", 32'(en_gen), 0);
    chk("rst_dst_valid", 32'(dst_valid), 0);
    chk("rst_beat_cnt", 32'(beat_cnt), 0);
    chk("rst_gen_ch", 32'(gen_ch), 0);
    chk("rst_dst_ch", 32'(dst_ch), 0);
    chk("rst_timeout", 32'(timeout_err), 0);
    model_reset();
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  task automatic full_packet(logic [3:0] sv);
    cyc(sv, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < PKT_LEN; i++) cyc(4'b0000, 1'b1, 1'b0, 1'b0);
  endtask

  initial begin
    int base, dv0, xf0, en0;
    reset        = 1'b1;
    src_valid    = '0;
    packet_valid = 1'b0;
    ack          = 1'b0;
    dst_ready    = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    do_reset();

    // 1: reset in the middle of GEN
    cyc(4'b0100, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) cyc(4'b0000, 1'b1, 1'b0, 1'b0);
    chk("t1_pre_beat", 32'(beat_cnt), 3);
    do_reset();
    cyc(4'b1111, 1'b0, 1'b0, 1'b0);
    chk("t1_rr_ptr", 32'(gen_ch), 0);
    dv0 = dv_cnt;
    for (int i = 0; i < PKT_LEN; i++) cyc(4'b0000, 1'b1, 1'b0, 1'b0);
    cyc(4'b0000, 1'b0, 1'b1, 1'b1);
    chk("t1_one_dv", dv_cnt - dv0, 1);

    // 2: all channels requesting
    do_reset();
    for (int k = 0; k < 5; k++) begin
      cyc(4'b1111, 1'b0, 1'b0, 1'b0);
      chk("t2_grant", 32'(gen_ch), k % NUM_CH);
      for (int i = 0; i < PKT_LEN; i++) cyc(4'b1111, 1'b1, 1'b0, 1'b0);
      cyc(4'b1111, 1'b0, 1'b1, 1'b1);
    end

    // 3: packet_valid toggling
    cyc(4'b0010, 1'b0, 1'b0, 1'b0);
    en0 = en_cnt;
    for (int i = 0; i < 2 * PKT_LEN; i++)
      cyc(4'b0000, 1'((i % 2) == 0), 1'b0, 1'b0);
    chk("t3_pulses", en_cnt - en0, PKT_LEN);
    cyc(4'b0000, 1'b1, 1'b0, 1'b0);
    chk("t3_no_extra", en_cnt - en0, PKT_LEN);
    chk("t3_in_process", 32'(busy), 1);

    // 4: ack with destination stalled
    dv0 = dv_cnt;
    xf0 = xfr_cnt;
    cyc(4'b0000, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) cyc(4'b0000, 1'b0, 1'b0, 1'b0);
    cyc(4'b0000, 1'b0, 1'b0, 1'b1);
    chk("t4_dv_cycles", dv_cnt - dv0, 6);
    chk("t4_transfers", xfr_cnt - xf0, 1);
    chk("t4_idle", 32'(busy), 0);

    // 5: ack and dst_ready together
    full_packet(4'b1000);
    dv0 = dv_cnt;
    cyc(4'b0000, 1'b0, 1'b1, 1'b1);
    chk("t5_dv_cycles", dv_cnt - dv0, 1);
    chk("t5_idle", 32'(busy), 0);

    // 6: ack never arrives
    full_packet(4'b0001);
    base    = cyc_n + 1;
    dv0     = dv_cnt;
    tmo_cyc = -1000;
    for (int i = 0; i < 40; i++) cyc(4'b0000, 1'b0, 1'b0, 1'b0);
    chk("t6_no_dv", dv_cnt - dv0, 0);
`ifdef ACK_TIMEOUT_EN
    chk("t6_timeout_at", tmo_cyc - base, ACK_TIMEOUT);
    chk("t6_idle", 32'(busy), 0);
    full_packet(4'b0010);
    for (int i = 0; i < ACK_TIMEOUT - 1; i++) cyc(4'b0000, 1'b0, 1'b0, 1'b0);
    dv0 = dv_cnt;
    cyc(4'b0000, 1'b0, 1'b1, 1'b1);
    chk("t6_ack_wins", dv_cnt - dv0, 1);
    cyc(4'b0000, 1'b0, 1'b0, 1'b0);
`else
    chk("t6_no_timeout", tmo_cyc, -1000);
    chk("t6_still_busy", 32'(busy), 1);
    cyc(4'b0000, 1'b0, 1'b1, 1'b1);
`endif

    // random traffic
    for (int i = 0; i < 2000; i++)
      cyc(4'($urandom_range(0, 15)),
          1'($urandom_range(0, 3) != 0),
          1'($urandom_range(0, 3) == 0),
          1'($urandom_range(0, 1)));

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

endmodule
